// File: rtl/fifo_umbral_pkg.sv
// Shared definitions for the threshold FIFO: one-hot global phase encodings
// and the decode from raw phase bits to the FIFO's own view of the phase.
package fifo_umbral_pkg;

   localparam logic [3:0] ST_RESET  = 4'b0001;
   localparam logic [3:0] ST_INIT   = 4'b0010;
   localparam logic [3:0] ST_IDLE   = 4'b0100;
   localparam logic [3:0] ST_ACTIVE = 4'b1000;

   // What the FIFO does in a given global phase.
   typedef enum logic [1:0] {
      PH_CLEAR,   // synchronous clear of occupancy state
      PH_LOAD,    // sample thresholds, traffic ignored
      PH_RUN      // push/pop honoured
   } phase_e;

   // IDLE, ACTIVE and any illegal encoding all behave as normal operation.
   function automatic phase_e decode_phase(input logic [3:0] st);
      case (st)
         ST_RESET: return PH_CLEAR;
         ST_INIT:  return PH_LOAD;
         default:  return PH_RUN;
      endcase
   endfunction

endpackage

// File: rtl/fifo_umbral_mem.sv
// Storage for fifo_umbral: DEPTH x DATA_W register array with one write port
// and one read port whose output is registered.
module fifo_mem
   import fifo_umbral_pkg::*;
#(
   parameter int DATA_W = 6,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // NOTE: the array is deliberately left without reset; occupancy logic
   // guarantees no slot is read before it is written, and a reset here would
   // stop the array mapping onto plain flops/RAM.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // NOTE: non-blocking assignments throughout sequential blocks; when a full
   // FIFO reads and writes the same slot on one edge, the read still sees the
   // old entry because both sides sample pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds.
// Occupancy is tracked by an explicit count; pointers only address storage.
module fifo_umbral
   import fifo_umbral_pkg::*;
#(
   parameter int DATA_W     = 6,
   parameter int DEPTH      = 8,
   parameter int ADDR_W     = 3,
   parameter int AF_DEFAULT = 6,
   parameter int AE_DEFAULT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        state,
   input  logic [ADDR_W:0]   umbral_af,
   input  logic [ADDR_W:0]   umbral_ae,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pop,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              error,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_RST_C = (ADDR_W+1)'(AF_DEFAULT);
   localparam logic [ADDR_W:0] AE_RST_C = (ADDR_W+1)'(AE_DEFAULT);

   phase_e phase;

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q,  count_d;
   logic [ADDR_W:0]   af_thr_q, af_thr_d;
   logic [ADDR_W:0]   ae_thr_q, ae_thr_d;
   logic              valid_q,  valid_d;
   logic              error_q,  error_d;
   logic              wr_en;
   logic              rd_en;

   assign phase = decode_phase(state);

   assign empty        = (count_q == '0);
   assign full         = (count_q == DEPTH_C);
   assign almost_full  = (count_q >= af_thr_q);
   assign almost_empty = (count_q <= ae_thr_q);

   // NOTE: every always_comb output gets a default before the case so that no
   // path leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      af_thr_d = af_thr_q;
      ae_thr_d = ae_thr_q;
      valid_d  = 1'b0;
      error_d  = error_q;
      wr_en    = 1'b0;
      rd_en    = 1'b0;

      case (phase)
         PH_CLEAR: begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            error_d  = 1'b0;
         end
         PH_LOAD: begin
            af_thr_d = (umbral_af > DEPTH_C) ? DEPTH_C : umbral_af;
            ae_thr_d = (umbral_ae > DEPTH_C) ? DEPTH_C : umbral_ae;
         end
         default: begin
            // A full FIFO still accepts a write when a read frees a slot on the same edge.
            wr_en   = push && (!full || pop);
            rd_en   = pop && !empty;
            valid_d = rd_en;

            if ((push && full && !pop) || (pop && empty)) begin
               error_d = 1'b1;
            end
            if (wr_en) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
               2'b10:   count_d = count_q + 1'b1;
               2'b01:   count_d = count_q - 1'b1;
               default: count_d = count_q;
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         af_thr_q <= AF_RST_C;
         ae_thr_q <= AE_RST_C;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         af_thr_q <= af_thr_d;
         ae_thr_q <= ae_thr_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
      end
   end

   assign valid_out = valid_q;
   assign error     = error_q;
   assign count     = count_q;

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (data_in),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (data_out)
   );

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Parameterised synchronous FIFO with programmable almost-full/almost-empty thresholds.
- Directly upstream of the arbiter: eight instances (four orange, four purple) supply its empty inputs and consume its pop strobes.
- Downstream instances supply almost_full back to the arbiter.
- Thresholds are loaded during the INIT phase of the global state machine.

Parameters:
DATA_W, 6, payload width in bits
DEPTH, 8, number of entries (power of two)
ADDR_W, 3, log2(DEPTH)
AF_DEFAULT, 6, almost-full threshold after reset
AE_DEFAULT, 1, almost-empty threshold after reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
state  input  4  global phase, one-hot (RESET/INIT/IDLE/ACTIVE)
umbral_af  input  ADDR_W+1  almost-full threshold, sampled in INIT
umbral_ae  input  ADDR_W+1  almost-empty threshold, sampled in INIT
push  input  1  write strobe
data_in  input  DATA_W  write data
pop  input  1  read strobe
data_out  output  DATA_W  registered read data
valid_out  output  1  data_out valid, one-cycle pulse
empty  output  1  count==0
full  output  1  count==DEPTH
almost_full  output  1  count>=af_thr
almost_empty  output  1  count<=ae_thr
error  output  1  sticky overflow/underflow flag
count  output  ADDR_W+1  current occupancy

Behaviour:
Asynchronous reset (reset=1):
- wr_ptr=rd_ptr=count=0; data_out=0, valid_out=0, error=0.
- af_thr=AF_DEFAULT, ae_thr=AE_DEFAULT.
- Resulting flags: empty=1, full=0, almost_full=0, almost_empty=1.

Phases (state is registered, one-hot):
- RESET (4'b0001): synchronous clear of pointers, count, valid_out and error. Thresholds kept. push/pop ignored.
- INIT (4'b0010): every cycle, af_thr<=min(umbral_af,DEPTH) and ae_thr<=min(umbral_ae,DEPTH). push/pop ignored.
- IDLE (4'b0100) and ACTIVE (4'b1000): push/pop honoured; thresholds frozen.
- Any other encoding: treated as IDLE.

Write:
- push && !full: mem[wr_ptr]<=data_in; wr_ptr wraps modulo DEPTH.
- push && full && !pop: write dropped, error<=1.

Read:
- pop && !empty: data_out<=mem[rd_ptr] and valid_out<=1 on the same edge; rd_ptr wraps modulo DEPTH.
- Read latency: one clock after the pop edge.
- Otherwise valid_out<=0; data_out holds its last value.
- pop && empty: ignored, error<=1, even if push is simultaneous.

Simultaneous push and pop:
- Not empty: both performed, count unchanged. This includes the full case, where the write lands in the slot just freed.
- Empty: write accepted, count becomes 1, error<=1.

Count and flags:
- count: +1 on accepted write only, -1 on accepted read only, never exceeds DEPTH.
- All flags are combinational from registered count and thresholds; no extra latency, visible the cycle after the causing edge.
- ae_thr>=af_thr is legal; both flags may be asserted together.

error:
- Sticky; cleared only by reset or the RESET phase.

Pointer wrap:
- 3-bit pointers for DEPTH=8; full/empty are decided by count, not pointer compare.

Decomposition:
- Shared package: one-hot phase constants ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE (4-bit), reused by arbiter and bench.
- Sub-module fifo_mem: DEPTH x DATA_W register array, one synchronous write port, one synchronous read port with registered output, no reset on storage.
- fifo_umbral holds pointers, count, thresholds, flags and the error logic.

Test Plan:
1. Reset, then INIT with umbral_af=5, umbral_ae=2, then ACTIVE -> af_thr=5, ae_thr=2; empty=1, almost_empty=1, count=0.
2. Push 0x01..0x05 on five cycles -> count=5, almost_full=1 after the fifth write, almost_empty=0 once count=3; pop five times -> data_out 0x01..0x05, each with valid_out one cycle after its pop.
3. Fill to 8, push 0x3F without pop -> full=1, write dropped, error=1, count=8; later pops return the original 8 values.
4. Full, push 0x2A with pop on the same cycle -> count stays 8, oldest entry read; after draining, 0x2A comes out last; error stays 0.
5. Empty, pop with push 0x11 on the same cycle -> error=1, count=1, valid_out=0; next pop returns 0x11.
6. Write 12 entries with interleaved pops to force pointer wrap, then assert async reset mid-burst -> all outputs return to reset values immediately. Also: state=RESET for one cycle clears error and count but keeps thresholds 5/2.
